// File: rtl/sdram_write_packer_if.sv
// ---------------------------------------------------------------------------
// sdram_write_packer_if
//   Bundles the loader-side byte write handshake and the SDRAM-side word
//   request handshake of sdram_write_packer.
//
//   Loader side : in_write_en, in_write_addr, in_write_data -> packer
//                 in_write_complete                          <- packer
//                 flush                                       -> packer
//   SDRAM side  : sdram_req, sdram_addr, sdram_data, sdram_be <- packer
//                 sdram_ack                                   -> packer
//   Status      : pending                                     <- packer
//
//   modport master : the packer (drives the SDRAM request)
//   modport slave  : the surrounding loader / SDRAM controller
// ---------------------------------------------------------------------------
interface sdram_write_packer_if #(
    parameter int ADDRESS_SIZE = 28
) ();
    logic                    in_write_en;
    logic [ADDRESS_SIZE-1:0] in_write_addr;
    logic [7:0]              in_write_data;
    logic                    in_write_complete;
    logic                    flush;
    logic                    sdram_req;
    logic                    sdram_ack;
    logic [ADDRESS_SIZE-2:0] sdram_addr;
    logic [15:0]             sdram_data;
    logic [1:0]              sdram_be;
    logic                    pending;

    modport master (
        input  in_write_en, in_write_addr, in_write_data, flush, sdram_ack,
        output in_write_complete, sdram_req, sdram_addr, sdram_data,
               sdram_be, pending
    );

    modport slave (
        output in_write_en, in_write_addr, in_write_data, flush, sdram_ack,
        input  in_write_complete, sdram_req, sdram_addr, sdram_data,
               sdram_be, pending
    );
endinterface

// File: rtl/sdram_write_packer.sv
// ---------------------------------------------------------------------------
// sdram_write_packer
//   Accepts byte writes from the APF data loader (level write_en, one-cycle
//   write_complete acknowledge) and issues 16-bit SDRAM word writes with byte
//   enables on a req/ack handshake. With SDRAM_WRITE_PACK_EN defined an even
//   byte is held so that the following odd byte of the same word can be
//   merged into one request; a held byte leaves alone on flush, on a
//   non-matching write, or after FLUSH_TIMEOUT cycles. Without the macro
//   every byte is issued on its own and flush is ignored.
//
//   Ports
//     clk_memory : memory clock (only clock)
//     reset      : synchronous, active-high
//     bus        : sdram_write_packer_if.master (loader + SDRAM handshakes)
//
//   Parameters
//     ADDRESS_SIZE  : byte address width (word address is one bit narrower)
//     FLUSH_TIMEOUT : cycles a lone even byte may wait in HOLD (>= 1)
// ---------------------------------------------------------------------------
module sdram_write_packer #(
    parameter int ADDRESS_SIZE  = 28,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                 clk_memory,
    input  logic                 reset,
    sdram_write_packer_if.master bus
);

    if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout
        $error("sdram_write_packer: FLUSH_TIMEOUT must be at least 1");
    end

`ifdef SDRAM_WRITE_PACK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, ISSUE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd2} state_t;
`endif

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_armed;
    logic                    r_complete;
    logic [ADDRESS_SIZE-2:0] r_addr;
    logic [15:0]             r_data;
    logic [1:0]              r_be;

    logic                    w_accept;
    logic                    w_take;
    logic                    w_odd;
    logic [ADDRESS_SIZE-2:0] w_waddr;

    // The loader holds write_en across the complete pulse; armed ensures a
    // single held request is accepted only once.
    assign w_take  = bus.in_write_en && r_armed;
    assign w_odd   = bus.in_write_addr[0];
    assign w_waddr = bus.in_write_addr[ADDRESS_SIZE-1:1];

`ifdef SDRAM_WRITE_PACK_EN
    localparam int CNT_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_match;
    logic             w_merge;

    // The held byte is always even, so a match is the odd byte of the same word.
    assign w_match = w_odd && (w_waddr == r_addr);
`else
    logic w_unused_flush;
    assign w_unused_flush = bus.flush;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
`ifdef SDRAM_WRITE_PACK_EN
        w_merge  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_accept = 1'b1;
`ifdef SDRAM_WRITE_PACK_EN
                    w_next   = w_odd ? ISSUE : HOLD;
`else
                    w_next   = ISSUE;
`endif
                end
            end
`ifdef SDRAM_WRITE_PACK_EN
            HOLD: begin
                // Merge takes priority over flush/timeout. A non-matching
                // write only pushes the held byte out; it is taken from IDLE.
                if (w_take && w_match) begin
                    w_accept = 1'b1;
                    w_merge  = 1'b1;
                    w_next   = ISSUE;
                end else if (w_take || bus.flush || (r_cnt == CNT_LAST)) begin
                    w_next   = ISSUE;
                end
            end
`endif
            ISSUE: begin
                if (bus.sdram_ack) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_state    <= IDLE;
            r_armed    <= 1'b1;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_complete <= w_accept;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!bus.in_write_en) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_be   <= '0;
`ifdef SDRAM_WRITE_PACK_EN
            r_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= w_waddr;
                        if (w_odd) begin
                            r_data <= {bus.in_write_data, 8'h00};
                            r_be   <= 2'b10;
                        end else begin
                            r_data <= {8'h00, bus.in_write_data};
`ifdef SDRAM_WRITE_PACK_EN
                            // Enables are set when HOLD decides how to leave.
                            r_be   <= 2'b00;
                            r_cnt  <= '0;
`else
                            r_be   <= 2'b01;
`endif
                        end
                    end
                end
`ifdef SDRAM_WRITE_PACK_EN
                HOLD: begin
                    if (w_merge) begin
                        r_data[15:8] <= bus.in_write_data;
                        r_be         <= 2'b11;
                    end else if (w_next == ISSUE) begin
                        r_be         <= 2'b01;
                    end else begin
                        r_cnt        <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_write_complete = r_complete;
    assign bus.sdram_req         = (r_state == ISSUE);
    assign bus.sdram_addr        = r_addr;
    assign bus.sdram_data        = r_data;
    assign bus.sdram_be          = r_be;
    assign bus.pending           = (r_state != IDLE);

endmodule

// File: tb/tb_sdram_write_packer.sv
// ---------------------------------------------------------------------------
// tb_sdram_write_packer
//   Directed bench for sdram_write_packer. A loader task drives byte writes
//   with the level write_en handshake; a responder process plays the SDRAM
//   controller (programmable ack delay), checks that the request stays
//   stable while waiting, and queues every acknowledged request with the
//   cycle it rose and the cycle ack was driven. Table vectors plus
//   hand-written sequences compare those records with expected values.
//   Build with or without SDRAM_WRITE_PACK_EN.
// ---------------------------------------------------------------------------
module tb_sdram_write_packer;

    localparam int AS = 28;
    localparam int FT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_write_packer_if #(.ADDRESS_SIZE(AS)) bus_if ();

    sdram_write_packer #(
        .ADDRESS_SIZE (AS),
        .FLUSH_TIMEOUT(FT)
    ) dut (
        .clk_memory(clk),
        .reset     (rst),
        .bus       (bus_if)
    );

    typedef struct {
        logic [AS-2:0] a;
        logic [15:0]   d;
        logic [1:0]    be;
        int            req_cyc;
        int            ack_cyc;
    } req_t;

    typedef struct {
        logic [AS-1:0] addr;
        logic [7:0]    d0;
        logic [7:0]    d1;
        bit            two;
        int            dly;
        logic [AS-2:0] ea;
        logic [15:0]   ed;
        logic [1:0]    ebe;
    } vec_t;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_writes  = 0;
    int   n_compl   = 0;
    int   cyc       = 0;
    int   ack_delay = 0;
    req_t rq_q[$];

    bit   rsp_busy   = 0;
    int   rsp_waited = 0;
    req_t rsp_cur;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus_if.in_write_complete === 1'b1) n_compl++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SDRAM controller model
    initial begin : responder
        bus_if.sdram_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_busy         = 0;
                bus_if.sdram_ack = 1'b0;
            end else if (bus_if.sdram_ack) begin
                bus_if.sdram_ack = 1'b0;
                rsp_busy         = 0;
            end else if (bus_if.sdram_req !== 1'b1) begin
                rsp_busy = 0;
            end else begin
                if (!rsp_busy) begin
                    rsp_busy        = 1;
                    rsp_waited      = 0;
                    rsp_cur.a       = bus_if.sdram_addr;
                    rsp_cur.d       = bus_if.sdram_data;
                    rsp_cur.be      = bus_if.sdram_be;
                    rsp_cur.req_cyc = cyc;
                end else begin
                    check("req_addr_stable", bus_if.sdram_addr, rsp_cur.a);
                    check("req_data_stable", bus_if.sdram_data, rsp_cur.d);
                    check("req_be_stable",   bus_if.sdram_be,   rsp_cur.be);
                end
                if (rsp_waited >= ack_delay) begin
                    bus_if.sdram_ack = 1'b1;
                    rsp_cur.ack_cyc  = cyc;
                    rq_q.push_back(rsp_cur);
                end else begin
                    rsp_waited++;
                end
            end
        end
    end

    // Loader: hold write_en until complete is seen, keep it one more cycle
    // (as a registered loader would), then drop it.
    task automatic do_write(input logic [AS-1:0] a, input logic [7:0] d,
                            input logic fl, output int ccyc);
        bit got = 0;
        @(negedge clk);
        bus_if.in_write_en   = 1'b1;
        bus_if.in_write_addr = a;
        bus_if.in_write_data = d;
        bus_if.flush         = fl;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus_if.in_write_complete === 1'b1) got = 1;
        end
        bus_if.flush = 1'b0;
        check("write_complete_seen", got, 1);
        ccyc = got ? cyc : -1;
        if (got) n_writes++;
        @(negedge clk);
        check("complete_single_cycle", bus_if.in_write_complete, 0);
        bus_if.in_write_en = 1'b0;
    endtask

    task automatic wait_req(input string name, output req_t r);
        bit got = 0;
        r = '{default: 0};
        for (int i = 0; i < 100 && !got; i++) begin
            if (rq_q.size() > 0) got = 1;
            else @(negedge clk);
        end
        check({name, "_req_seen"}, got, 1);
        if (got) r = rq_q.pop_front();
    endtask

    task automatic check_req(input string name, input req_t r, input logic [AS-2:0] ea,
                             input logic [15:0] ed, input logic [1:0] ebe);
        logic [15:0] m;
        m = {{8{ebe[1]}}, {8{ebe[0]}}};
        check({name, "_addr"}, r.a, ea);
        check({name, "_be"},   r.be, ebe);
        check({name, "_data"}, r.d & m, ed & m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.in_write_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_req",      bus_if.sdram_req, 0);
        check("rst_pending",  bus_if.pending, 0);
        check("rst_complete", bus_if.in_write_complete, 0);
        check("rst_be",       bus_if.sdram_be, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[$];
        req_t r, r2;
        int   c, c2;

        bus_if.in_write_en   = 1'b0;
        bus_if.in_write_addr = '0;
        bus_if.in_write_data = '0;
        bus_if.flush         = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_req",      bus_if.sdram_req, 0);
        check("reset_complete", bus_if.in_write_complete, 0);
        check("reset_pending",  bus_if.pending, 0);
        check("reset_addr",     bus_if.sdram_addr, 0);
        check("reset_data",     bus_if.sdram_data, 0);
        check("reset_be",       bus_if.sdram_be, 0);
        rst = 1'b0;

`ifdef SDRAM_WRITE_PACK_EN
        vecs.push_back('{28'h0000100, 8'hAA, 8'h55, 1'b1, 0, 27'h0000080, 16'h55AA, 2'b11});
        vecs.push_back('{28'h0002468, 8'h3C, 8'hC3, 1'b1, 2, 27'h0001234, 16'hC33C, 2'b11});
        vecs.push_back('{28'h0000101, 8'h77, 8'h00, 1'b0, 0, 27'h0000080, 16'h7700, 2'b10});
        vecs.push_back('{28'hFFFFFFE, 8'h01, 8'h02, 1'b1, 1, 27'h7FFFFFF, 16'h0201, 2'b11});
        vecs.push_back('{28'h0000002, 8'h99, 8'h00, 1'b0, 0, 27'h0000001, 16'h0099, 2'b01});
`else
        vecs.push_back('{28'h0000100, 8'hAA, 8'h00, 1'b0, 0, 27'h0000080, 16'h00AA, 2'b01});
        vecs.push_back('{28'h0000101, 8'h55, 8'h00, 1'b0, 0, 27'h0000080, 16'h5500, 2'b10});
        vecs.push_back('{28'h0000001, 8'hFF, 8'h00, 1'b0, 0, 27'h0000000, 16'hFF00, 2'b10});
        vecs.push_back('{28'hFFFFFFE, 8'h12, 8'h00, 1'b0, 1, 27'h7FFFFFF, 16'h0012, 2'b01});
        vecs.push_back('{28'hFFFFFFF, 8'h34, 8'h00, 1'b0, 0, 27'h7FFFFFF, 16'h3400, 2'b10});
        vecs.push_back('{28'h0002468, 8'hC3, 8'h00, 1'b0, 3, 27'h0001234, 16'h00C3, 2'b01});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            ack_delay = vecs[i].dly;
            do_write(vecs[i].addr, vecs[i].d0, 1'b0, c);
            if (vecs[i].two) do_write(vecs[i].addr | 28'h1, vecs[i].d1, 1'b0, c);
            wait_req($sformatf("vec%0d", i), r);
            check_req($sformatf("vec%0d", i), r, vecs[i].ea, vecs[i].ed, vecs[i].ebe);
        end
        repeat (4) @(negedge clk);
        check("vec_no_extra_req", rq_q.size(), 0);

`ifdef SDRAM_WRITE_PACK_EN
        // Lone even byte leaves on timeout
        ack_delay = 0;
        do_write(28'h200, 8'h11, 1'b0, c);
        wait_req("timeout", r);
        check_req("timeout", r, 27'h100, 16'h0011, 2'b01);
        check("timeout_latency", r.req_cyc - c, FT);

        // Non-matching write pushes the held byte out and waits for the ack
        ack_delay = 4;
        do_write(28'h10, 8'h01, 1'b0, c);
        do_write(28'h20, 8'h02, 1'b0, c2);
        wait_req("nomatch1", r);
        check_req("nomatch1", r, 27'h08, 16'h0001, 2'b01);
        check("nomatch_complete_after_ack", c2 - r.ack_cyc, 2);
        wait_req("nomatch2", r2);
        check_req("nomatch2", r2, 27'h10, 16'h0002, 2'b01);
        check("nomatch2_timeout", r2.req_cyc - c2, FT);

        // Explicit flush of a held byte
        ack_delay = 0;
        do_write(28'h500, 8'h9A, 1'b0, c);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        wait_req("flush", r);
        check_req("flush", r, 27'h280, 16'h009A, 2'b01);
        check("flush_latency", r.req_cyc - c, 2);

        // Flush in IDLE does nothing
        repeat (3) @(negedge clk);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        check("flush_idle_pending", bus_if.pending, 0);

        // Merge wins over a simultaneous flush
        do_write(28'h600, 8'h01, 1'b0, c);
        do_write(28'h601, 8'h02, 1'b1, c);
        wait_req("merge_flush", r);
        check_req("merge_flush", r, 27'h300, 16'h0201, 2'b11);
`endif

        // Slow ack while another write is pending
        ack_delay = 10;
        do_write(28'h305, 8'h5A, 1'b0, c);
        do_write(28'h307, 8'hA5, 1'b0, c2);
        wait_req("slow1", r);
        check_req("slow1", r, 27'h182, 16'h5A00, 2'b10);
        check("slow1_req_cycle", r.req_cyc, c);
        check("slow_complete_after_ack", c2 - r.ack_cyc, 2);
        wait_req("slow2", r2);
        check_req("slow2", r2, 27'h183, 16'hA500, 2'b10);
        check("slow2_req_cycle", r2.req_cyc, c2);

        // Reset drops a held byte and an outstanding request
        repeat (2) @(negedge clk);
        ack_delay = 1000;
`ifdef SDRAM_WRITE_PACK_EN
        do_write(28'h400, 8'hEE, 1'b0, c);
        check("hold_pending", bus_if.pending, 1);
        do_reset();
`endif
        do_write(28'h101, 8'h77, 1'b0, c);
        check("issue_req_before_reset", bus_if.sdram_req, 1);
        do_reset();
        ack_delay = 0;
        do_write(28'h301, 8'h3C, 1'b0, c);
        wait_req("post_reset", r);
        check_req("post_reset", r, 27'h180, 16'h3C00, 2'b10);
        repeat (FT + 10) @(negedge clk);
        check("post_reset_no_extra_req", rq_q.size(), 0);
        check("complete_count", n_compl, n_writes);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
